// File: rtl/lcd_cmd_arbiter_if.sv
// Requester/driver-side signal bundle for lcd_cmd_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface lcd_cmd_arbiter_if;
  logic       req0;
  logic       req1;
  logic [9:0] cmd0;
  logic [9:0] cmd1;
  logic       ack0;
  logic       ack1;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       busy;
  logic       err;

  modport master (
    output req0, req1, cmd0, cmd1, busy,
    input  ack0, ack1, lcd_enable, lcd_bus, err
  );

  modport slave (
    input  req0, req1, cmd0, cmd1, busy,
    output ack0, ack1, lcd_enable, lcd_bus, err
  );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter feeding two command requesters into one LCD driver,
// with busy handshake, busy-rise timeout (sticky err) and post-command gap.
module lcd_cmd_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 8
) (
  input logic              clk,
  input logic              rst,
  lcd_cmd_arbiter_if.slave io
);

  localparam int TW = (TIMEOUT    > 0) ? $clog2(TIMEOUT + 1)    : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  // Last counter value before leaving the state; counters stop there, never wrap.
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT    > 0) ? TIMEOUT - 1    : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP} state_t;

  state_t          state, state_d;
  logic            en_q, en_d;
  logic [9:0]      bus_q, bus_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            err_q, err_d;
  logic            last_q, last_d;   // 1 = requester 1 granted last
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [GW-1:0]   gcnt, gcnt_d;
  logic            pick1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      en_q   <= 1'b0;
      bus_q  <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q  <= 1'b0;
      last_q <= 1'b1;
      tcnt   <= '0;
      gcnt   <= '0;
    end else begin
      state  <= state_d;
      en_q   <= en_d;
      bus_q  <= bus_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      err_q  <= err_d;
      last_q <= last_d;
      tcnt   <= tcnt_d;
      gcnt   <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    en_d    = 1'b0;
    bus_d   = bus_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = err_q;
    last_d  = last_q;
    tcnt_d  = tcnt;
    gcnt_d  = gcnt;
    pick1   = io.req1 && (!io.req0 || !last_q);
    unique case (state)
      IDLE: begin
        // Driver busy (including its power-up init) blocks any new issue.
        if (!io.busy && (io.req0 || io.req1)) begin
          last_d  = pick1;
          bus_d   = pick1 ? io.cmd1 : io.cmd0;
          en_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (io.busy) begin
          state_d = WAIT_LO;
        end else if (tcnt >= TO_LAST) begin
          err_d   = 1'b1;
          ack0_d  = !last_q;
          ack1_d  = last_q;
          gcnt_d  = '0;
          state_d = GAP;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!io.busy) begin
          ack0_d  = !last_q;
          ack1_d  = last_q;
          gcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gcnt >= GAP_LAST) state_d = IDLE;
        else                  gcnt_d  = gcnt + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.lcd_enable = en_q;
  assign io.lcd_bus    = bus_q;
  assign io.ack0       = ack0_q;
  assign io.ack1       = ack1_q;
  assign io.err        = err_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Randomized self-checking bench for lcd_cmd_arbiter: the bench plays both
// requesters and the LCD driver, and predicts grants/acks/timing per transaction.
module tb_lcd_cmd_arbiter;
  localparam int GAP = 2;
  localparam int TO  = 8;
  localparam int G   = (GAP > 1) ? GAP : 1;   // cycles spent in the post-ack gap

  logic clk = 1'b0;
  logic rst;
  lcd_cmd_arbiter_if io();

  lcd_cmd_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_last = 1;   // model: last granted requester
  bit m_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Drive requests, predict the winner, wait for the strobe and check its latency/word.
  task automatic issue(input bit r0, input bit r1, input logic [9:0] c0, input logic [9:0] c1,
                       input int exp_wait, output int w, output logic [9:0] word);
    int n = 0;
    io.req0 = r0; io.req1 = r1; io.cmd0 = c0; io.cmd1 = c1; io.busy = 1'b0;
    if (r0 && r1) w = (m_last == 1) ? 0 : 1;
    else          w = r0 ? 0 : 1;
    m_last = w;
    word   = w ? c1 : c0;
    do begin
      @(negedge clk);
      n++;
    end while (!io.lcd_enable && n < 40);
    chk("issue_delay", n, exp_wait);
    chk("issue_bus", io.lcd_bus, word);
  endtask

  // Called at the strobe cycle. Busy rises at cycle k after the strobe for L cycles;
  // k beyond TO means busy never rises and the command times out.
  task automatic serve(input int w, input logic [9:0] word, input int k, input int L);
    bit to = (k > TO);
    int a  = to ? TO + 1 : k + L + 1;
    for (int n = 0; n <= a; n++) begin
      if (n > 0) begin
        chk("hold_bus", io.lcd_bus, word);
        chk("enable_low", io.lcd_enable, 0);
        chk("ack0", io.ack0, (n == a && w == 0));
        chk("ack1", io.ack1, (n == a && w == 1));
        if (n == a) begin
          if (to) m_err = 1'b1;
          chk("err", io.err, m_err);
        end
      end
      if (n < a) begin
        io.busy = !to && n >= k && n < k + L;
        io.cmd0 = 10'($urandom);
        io.cmd1 = 10'($urandom);
        io.req0 = 1'($urandom);
        io.req1 = 1'($urandom);
        @(negedge clk);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},   io.lcd_enable, 0);
    chk({tag, "_bus"},  io.lcd_bus, 0);
    chk({tag, "_ack0"}, io.ack0, 0);
    chk({tag, "_ack1"}, io.ack1, 0);
    chk({tag, "_err"},  io.err, 0);
  endtask

  initial begin
    int w, n, k;
    bit r0, r1;
    logic [9:0] word, c0, c1;

    rst = 1'b1;
    io.req0 = 1'b0; io.req1 = 1'b0; io.cmd0 = '0; io.cmd1 = '0; io.busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Driver init: busy held high must block the strobe.
    io.busy = 1'b1; io.req0 = 1'b1; io.req1 = 1'b0; io.cmd0 = 10'h155;
    n = 0;
    repeat (600) begin
      @(negedge clk);
      if (io.lcd_enable) n++;
    end
    chk("init_hold", n, 0);
    issue(1'b1, 1'b0, 10'h155, 10'h0AA, 1, w, word);
    serve(w, word, 1, 3);

    // Single long command.
    issue(1'b1, 1'b0, 10'h230, 10'h3FF, G + 1, w, word);
    chk("single_word", word, 10'h230);
    serve(w, word, 1, 51);

    // Continuous tie: last grant was 0, so order is 1,0,1,0.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 10'($urandom), 10'($urandom), G + 1, w, word);
      chk("tie_gnt", w, (i % 2 == 0) ? 1 : 0);
      serve(w, word, $urandom_range(1, TO), 2);
    end

    // Busy rising exactly at the last allowed cycle is not a timeout.
    issue(1'b0, 1'b1, 10'h011, 10'h122, G + 1, w, word);
    serve(w, word, TO, 2);
    chk("no_err_yet", io.err, 0);

    // Timeout, then a normal command with err still set.
    issue(1'b1, 1'b0, 10'h2AB, 10'h1CD, G + 1, w, word);
    serve(w, word, TO + 1, 0);
    issue(1'b0, 1'b1, 10'h001, 10'h3C3, G + 1, w, word);
    serve(w, word, 2, 4);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      k = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(1, TO);
      issue(r0, r1, 10'($urandom), 10'($urandom), G + 1, w, word);
      serve(w, word, k, $urandom_range(1, 6));
    end

    // Reset while the driver is busy: no ack, outputs cleared, req0 wins next tie.
    issue(1'b1, 1'b0, 10'h3A5, 10'h05A, G + 1, w, word);
    io.busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b0; io.busy = 1'b0; io.req0 = 1'b0; io.req1 = 1'b0;
    m_last = 1; m_err = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (io.ack0 || io.ack1 || io.lcd_enable) n++;
    end
    chk("post_reset_quiet", n, 0);
    issue(1'b1, 1'b1, 10'h0F0, 10'h30F, 1, w, word);
    chk("post_reset_gnt", w, 0);
    serve(w, word, 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
